axis_packet_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares the single 64-bit AXI-Stream port into the PS DMA FIFO between N_CH acquisition channels. Each channel supplies event words through its own FIFO read interface. The block grants one channel at a time for exactly one packet of `packet_size` beats and generates TLAST on the final beat. If the granted channel stalls mid-packet, the block pads the packet to full length with fill words, so the DMA never waits indefinitely on a partial packet. It sits between the per-channel event FIFOs and the fifo_S_AXIS port, and its configuration comes from the system-bus register file.

---
 rtl/axis_packet_arbiter.sv | 166 ++++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin arbiter. It merges N_CH first-word-fall-through
// event FIFOs onto one AXI-Stream master. Each grant carries exactly one
// packet of psize beats with TLAST on the final beat. A stalled channel
// has its packet padded to full length with PAD_WORD once the stall timeout
// expires.
module axis_packet_arbiter #(
    parameter int                N_CH     = 2,
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] PAD_WORD = {DATA_W{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rstn_i,
    input  logic                   enable,
    input  logic [31:0]            packet_size,
    input  logic [31:0]            timeout_cycles,
    input  logic [N_CH*DATA_W-1:0] ch_tdata,
    input  logic [N_CH-1:0]        ch_tvalid,
    output logic [N_CH-1:0]        ch_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [DATA_W/8-1:0]    m_tkeep,
    output logic [3:0]             m_tuser,
    output logic                   busy,
    output logic [31:0]            pkt_count,
    output logic [31:0]            pad_count
);

    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, SEND, PAD} state_t;

    state_t          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   last_grant_q;
    logic [31:0]     psize_q;
    logic [31:0]     beat_cnt_q;
    logic [31:0]     stall_cnt_q;
    logic [31:0]     pkt_count_q;
    logic [31:0]     pad_count_q;

    logic [DATA_W-1:0] ch_words [N_CH];
    logic              hi_found, lo_found, req_found;
    logic [GW-1:0]     hi_idx, lo_idx, req_idx;
    logic              beat_last;
    logic              grant_valid;

    // Split the flat channel bus into one word per channel and drive the
    // per-channel read strobes (only the granted channel, only while sending).
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign ch_words[gi]  = ch_tdata[gi*DATA_W +: DATA_W];
        assign ch_tready[gi] = (state_q == SEND) && (grant_q == GW'(gi)) && m_tready;
    end

    assign grant_valid = ch_tvalid[grant_q];
    assign beat_last   = (beat_cnt_q == psize_q - 32'd1);

    // Round-robin pick: lowest requester above last_grant, else lowest at or below it.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (ch_tvalid[k]) begin
                if (GW'(k) > last_grant_q) begin
                    hi_found = 1'b1;
                    hi_idx   = GW'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = GW'(k);
                end
            end
        end
        req_found = hi_found | lo_found;
        req_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Packet FSM: grant, pass words through, pad on stall timeout, count completions.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_CH - 1);
            psize_q      <= '0;
            beat_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            pkt_count_q  <= '0;
            pad_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && req_found) begin
                        grant_q     <= req_idx;
                        psize_q     <= (packet_size == 32'd0) ? 32'd1 : packet_size;
                        beat_cnt_q  <= '0;
                        stall_cnt_q <= '0;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (grant_valid && m_tready) begin
                        beat_cnt_q <= beat_cnt_q + 32'd1;
                        if (beat_last) begin
                            pkt_count_q  <= pkt_count_q + 32'd1;
                            last_grant_q <= grant_q;
                            state_q      <= IDLE;
                        end
                    end
                    // A stall cannot coincide with a beat, so the PAD move never races completion.
                    if (grant_valid) begin
                        stall_cnt_q <= '0;
                    end else begin
                        stall_cnt_q <= stall_cnt_q + 32'd1;
                        if ((timeout_cycles != 32'd0) &&
                            (stall_cnt_q == timeout_cycles - 32'd1)) begin
                            state_q <= PAD;
                        end
                    end
                end
                PAD: begin
                    if (m_tready) begin
                        beat_cnt_q  <= beat_cnt_q + 32'd1;
                        pad_count_q <= pad_count_q + 32'd1;
                        if (beat_last) begin
                            pkt_count_q  <= pkt_count_q + 32'd1;
                            last_grant_q <= grant_q;
                            state_q      <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stream outputs: FWFT passthrough in SEND, constant fill in PAD, quiet in IDLE.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = 4'd0;
        case (state_q)
            SEND: begin
                m_tdata  = ch_words[grant_q];
                m_tvalid = grant_valid;
                m_tlast  = beat_last;
                m_tuser  = {1'b0, 3'(grant_q)};
            end
            PAD: begin
                m_tdata  = PAD_WORD;
                m_tvalid = 1'b1;
                m_tlast  = beat_last;
                m_tuser  = {1'b1, 3'(grant_q)};
            end
            default: ;
        endcase
    end

    assign m_tkeep   = '1;
    assign busy      = (state_q != IDLE);
    assign pkt_count = pkt_count_q;
    assign pad_count = pad_count_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: per-channel FWFT FIFOs are modelled as
// queues, and the expected beat stream is built packet by packet from the
// round-robin and padding rules.
module tb_axis_packet_arbiter;

    localparam int N_CH   = 2;
    localparam int DATA_W = 64;
    localparam logic [63:0] PAD = 64'hFFFF_FFFF_FFFF_FFFF;

    logic                   clk = 1'b0;
    logic                   rstn_i;
    logic                   enable;
    logic [31:0]            packet_size;
    logic [31:0]            timeout_cycles;
    logic [N_CH*DATA_W-1:0] ch_tdata;
    logic [N_CH-1:0]        ch_tvalid;
    logic [N_CH-1:0]        ch_tready;
    logic [DATA_W-1:0]      m_tdata;
    logic                   m_tvalid;
    logic                   m_tready;
    logic                   m_tlast;
    logic [DATA_W/8-1:0]    m_tkeep;
    logic [3:0]             m_tuser;
    logic                   busy;
    logic [31:0]            pkt_count;
    logic [31:0]            pad_count;

    always #5 clk = ~clk;

    axis_packet_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .PAD_WORD(PAD)) dut (
        .clk(clk), .rstn_i(rstn_i), .enable(enable), .packet_size(packet_size),
        .timeout_cycles(timeout_cycles), .ch_tdata(ch_tdata), .ch_tvalid(ch_tvalid),
        .ch_tready(ch_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
        .busy(busy), .pkt_count(pkt_count), .pad_count(pad_count)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [3:0]  user;
        int          cyc;
    } beat_t;

    beat_t       got[$];
    beat_t       exp_q[$];
    logic [63:0] chq0[$], chq1[$];   // words the FIFOs still hold
    logic [63:0] mq0[$],  mq1[$];    // words the model has not yet placed in a packet
    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    int          rmode  = 0;         // 0: ready high, 1: toggle, 2: random
    int          model_last = N_CH - 1;
    int          exp_pkts = 0;
    int          exp_pads = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive_inputs();
        ch_tvalid[0]     = (chq0.size() > 0);
        ch_tvalid[1]     = (chq1.size() > 0);
        ch_tdata[63:0]   = (chq0.size() > 0) ? chq0[0] : 64'd0;
        ch_tdata[127:64] = (chq1.size() > 0) ? chq1[0] : 64'd0;
        case (rmode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One clock: sample mid-cycle, then apply FIFO pops and new inputs after the edge.
    task automatic tick();
        logic pop0, pop1;
        @(negedge clk);
        cyc++;
        if (prev_stall) begin
            chk("hold_valid", m_tvalid, 1'b1);
            chk("hold_data", m_tdata, prev_data);
            chk("hold_last", m_tlast, prev_last);
        end
        chk("ready_onehot", ($countones(ch_tready) <= 1), 1'b1);
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        if (m_tvalid && m_tready) got.push_back('{m_tdata, m_tlast, m_tuser, cyc});
        pop0 = ch_tready[0] && ch_tvalid[0];
        pop1 = ch_tready[1] && ch_tvalid[1];
        @(posedge clk);
        #1;
        if (pop0) void'(chq0.pop_front());
        if (pop1) void'(chq1.pop_front());
        drive_inputs();
    endtask

    task automatic load(input int k, input int n);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            if (k == 0) begin chq0.push_back(w); mq0.push_back(w); end
            else        begin chq1.push_back(w); mq1.push_back(w); end
        end
        drive_inputs();
    endtask

    // Expected packet from channel k: nreal channel words then fill up to the packet length.
    task automatic exp_pkt(input int k, input int ps, input int nreal);
        int    eff;
        beat_t b;
        eff = (ps == 0) ? 1 : ps;
        for (int i = 0; i < eff; i++) begin
            if (i < nreal) begin
                b.data = (k == 0) ? mq0.pop_front() : mq1.pop_front();
                b.user = {1'b0, 3'(k)};
            end else begin
                b.data = PAD;
                b.user = {1'b1, 3'(k)};
                exp_pads++;
            end
            b.last = (i == eff - 1);
            b.cyc  = 0;
            exp_q.push_back(b);
        end
        exp_pkts++;
        model_last = k;
    endtask

    task automatic run_until(input int n, input int budget);
        int b = 0;
        while (got.size() < n && b < budget) begin
            tick();
            b++;
        end
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_beats"}, 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), got[i].data, exp_q[i].data);
            chk($sformatf("%s_last%0d", tag, i), got[i].last, exp_q[i].last);
            chk($sformatf("%s_user%0d", tag, i), got[i].user, exp_q[i].user);
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_pkt_count"}, pkt_count, 64'(exp_pkts));
        chk({tag, "_pad_count"}, pad_count, 64'(exp_pads));
    endtask

    initial begin
        int s, ps, k;
        rstn_i = 1'b0; enable = 1'b0; packet_size = 32'd4; timeout_cycles = 32'd0;
        ch_tdata = '0; ch_tvalid = '0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_ch_tready", ch_tready, 2'b00);
        chk("rst_tuser", m_tuser, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tkeep", m_tkeep, 8'hFF);
        chk_counts("rst");
        rstn_i = 1'b1;
        enable = 1'b1;

        // Single channel, two packets of 4, one arbitration cycle between them
        load(0, 8);
        s = cyc;
        exp_pkt(0, 4, 4);
        exp_pkt(0, 4, 4);
        run_until(8, 40);
        if (got.size() >= 8) begin
            chk("t1_latency", 64'(got[0].cyc - s), 64'd2);
            chk("t1_gap", 64'(got[4].cyc - got[3].cyc), 64'd2);
        end
        compare("t1");
        chk_counts("t1");
        chk("t1_busy", busy, 1'b0);

        // Both channels always valid: strict alternation, whole packets of 3
        packet_size = 32'd3;
        load(0, 9);
        load(1, 9);
        for (int p = 0; p < 6; p++) exp_pkt((model_last + 1) % N_CH, 3, 3);
        run_until(18, 80);
        if (got.size() >= 4) chk("t2_gap", 64'(got[3].cyc - got[2].cyc), 64'd2);
        compare("t2");
        chk_counts("t2");

        // Stall after 2 words with timeout 10: 3 fill beats complete the packet
        packet_size = 32'd5;
        timeout_cycles = 32'd10;
        k = (model_last + 1) % N_CH;
        load(k, 2);
        exp_pkt(k, 5, 2);
        run_until(5, 60);
        if (got.size() >= 3) chk("t3_pad_delay", 64'(got[2].cyc - got[1].cyc), 64'd11);
        compare("t3");
        chk_counts("t3");

        // Same stall without timeout: packet stays open until the words arrive
        timeout_cycles = 32'd0;
        k = (model_last + 1) % N_CH;
        load(k, 2);
        repeat (40) tick();
        chk("t4_open_beats", 64'(got.size()), 64'd2);
        chk("t4_open_busy", busy, 1'b1);
        load(k, 3);
        exp_pkt(k, 5, 5);
        run_until(5, 20);
        compare("t4");
        chk_counts("t4");

        // Enable dropped mid-packet: packet finishes, no new grant follows
        packet_size = 32'd4;
        k = (model_last + 1) % N_CH;
        load(k, 4);
        run_until(2, 10);
        enable = 1'b0;
        exp_pkt(k, 4, 4);
        run_until(4, 10);
        compare("t5");
        load(1 - k, 2);
        repeat (10) tick();
        chk("t5_no_grant_beats", 64'(got.size()), 64'd0);
        chk("t5_no_grant_busy", busy, 1'b0);
        enable = 1'b1;
        packet_size = 32'd2;
        exp_pkt(1 - k, 2, 2);
        run_until(2, 10);
        compare("t5b");
        chk_counts("t5");

        // packet_size 0 under toggling ready: every beat is its own packet
        rmode = 1;
        packet_size = 32'd0;
        load(0, 4);
        load(1, 4);
        for (int p = 0; p < 8; p++) exp_pkt((model_last + 1) % N_CH, 0, 1);
        run_until(8, 80);
        compare("t6");
        chk_counts("t6");

        // Random ready, random packet sizes, timeout armed but never reached
        rmode = 2;
        for (int r = 0; r < 3; r++) begin
            ps = $urandom_range(0, 4);
            packet_size = 32'(ps);
            timeout_cycles = 32'($urandom_range(20, 60));
            load(0, 12);
            load(1, 12);
            for (int p = 0; p < 24 / ((ps == 0) ? 1 : ps); p++)
                exp_pkt((model_last + 1) % N_CH, ps, (ps == 0) ? 1 : ps);
            run_until(24, 400);
            compare($sformatf("rnd%0d", r));
            chk_counts($sformatf("rnd%0d", r));
        end

        // Reset in the middle of a channel-1 packet
        rmode = 0;
        timeout_cycles = 32'd0;
        packet_size = 32'd8;
        load(1, 8);
        run_until(3, 20);
        chk("t7_mid_busy", busy, 1'b1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("t7_rst_tvalid", m_tvalid, 1'b0);
        chk("t7_rst_tlast", m_tlast, 1'b0);
        chk("t7_rst_ch_tready", ch_tready, 2'b00);
        chk("t7_rst_tuser", m_tuser, 4'd0);
        chk("t7_rst_busy", busy, 1'b0);
        chk("t7_rst_pkt_count", pkt_count, 32'd0);
        chk("t7_rst_pad_count", pad_count, 32'd0);
        chq0.delete(); chq1.delete(); mq0.delete(); mq1.delete();
        got.delete(); exp_q.delete();
        model_last = N_CH - 1;
        exp_pkts = 0;
        exp_pads = 0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
        packet_size = 32'd1;
        load(0, 1);
        load(1, 1);
        exp_pkt(0, 1, 1);
        exp_pkt(1, 1, 1);
        run_until(2, 10);
        compare("t7");
        chk_counts("t7");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
